// File: rtl/pipe_pkg.sv
// Shared constants for the inter-stage pipeline registers: per-boundary
// payload/control widths and the stage occupancy state encoding.
package pipe_pkg;

    localparam int unsigned IFID_DATA_W  = 96;
    localparam int unsigned IFID_CTRL_W  = 4;
    localparam int unsigned IDEX_DATA_W  = 160;
    localparam int unsigned IDEX_CTRL_W  = 12;
    localparam int unsigned EXMEM_DATA_W = 64;
    localparam int unsigned EXMEM_CTRL_W = 8;
    localparam int unsigned MEMWB_DATA_W = 64;
    localparam int unsigned MEMWB_CTRL_W = 4;

    // State value doubles as the occupancy count.
    typedef logic [1:0] stage_state_t;

    localparam stage_state_t ST_EMPTY = 2'd0;
    localparam stage_state_t ST_ONE   = 2'd1;
    localparam stage_state_t ST_TWO   = 2'd2;

endpackage

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush, and an
// optional skid entry that makes in_ready a purely registered signal.
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_EMPTY | nothing held, out_valid=0, out_ctrl forced to zero
// ST_ONE   | main entry valid and presented downstream
// ST_TWO   | main and skid valid (SKID=1 only), upstream blocked
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CTRL_W = 8,
    parameter bit          SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    stage_state_t      state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic              valid_s;
    logic              push;
    logic              pop;
    logic              load_main_in;
    logic              load_main_skid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // A push in ST_ONE without a pop only happens with SKID=1, because the
    // single-entry in_ready requires out_ready whenever the stage is full.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push && !pop) begin
                    state_d = ST_TWO;
                end else if (!push && pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
        end
    end

    always_comb begin
        valid_s   = (state_q != ST_EMPTY);
        out_valid = valid_s;
        occupancy = state_q;
        out_data  = main_data_q;
        out_ctrl  = main_ctrl_q;
        if (SKID) begin
            in_ready = rst && (state_q != ST_TWO);
        end else begin
            in_ready = rst && (!valid_s || out_ready);
        end
    end

    assign push = in_valid && in_ready;
    assign pop  = valid_s && out_ready;

    // Flush freezes the payload; only the control field is cleared.
    always_comb begin
        main_data_d    = main_data_q;
        main_ctrl_d    = main_ctrl_q;
        load_main_in   = push && !flush && ((state_q == ST_EMPTY) || pop);
        load_main_skid = pop && !flush && (state_q == ST_TWO);
        if (load_main_in) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
        end else if (load_main_skid) begin
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
        end
        if (state_d == ST_EMPTY) begin
            main_ctrl_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            main_data_q <= '0;
            main_ctrl_q <= '0;
        end else begin
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
        end
    end

    if (SKID) begin : g_skid
        logic [DATA_W-1:0] skid_data_d;
        logic [CTRL_W-1:0] skid_ctrl_d;

        always_comb begin
            skid_data_d = skid_data_q;
            skid_ctrl_d = skid_ctrl_q;
            if (flush) begin
                skid_ctrl_d = '0;
            end else if (push && !pop && (state_q == ST_ONE)) begin
                skid_data_d = in_data;
                skid_ctrl_d = in_ctrl;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                skid_data_q <= '0;
                skid_ctrl_q <= '0;
            end else begin
                skid_data_q <= skid_data_d;
                skid_ctrl_q <= skid_ctrl_d;
            end
        end
    end else begin : g_no_skid
        assign skid_data_q = '0;
        assign skid_ctrl_q = '0;
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid and a single-entry stage share stimulus
// and are both compared against a FIFO model, plus directed vectors.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int DW = EXMEM_DATA_W;
    localparam int CW = EXMEM_CTRL_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, flush, in_valid, out_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          in_ready_w  [2];
    logic          out_valid_w [2];
    logic [DW-1:0] out_data_w  [2];
    logic [CW-1:0] out_ctrl_w  [2];
    logic [1:0]    occ_w       [2];

    int total = 0;
    int bad   = 0;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1)) u_skid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_w[0]),
        .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid_w[0]), .out_ready(out_ready),
        .out_data(out_data_w[0]), .out_ctrl(out_ctrl_w[0]),
        .occupancy(occ_w[0])
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b0)) u_noskid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_w[1]),
        .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid_w[1]), .out_ready(out_ready),
        .out_data(out_data_w[1]), .out_ctrl(out_ctrl_w[1]),
        .occupancy(occ_w[1])
    );

    // Reference: bounded FIFO (capacity 2 or 1) plus the last payload shown.
    logic [DW-1:0] m_data  [2][2];
    logic [CW-1:0] m_ctrl  [2][2];
    int            m_cnt   [2];
    logic [DW-1:0] m_shown [2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic model_ready(input int k);
        if (!rst) return 1'b0;
        if (k == 0) return (m_cnt[k] < 2);
        return (m_cnt[k] == 0) || out_ready;
    endfunction

    task automatic model_edge(input int k, input bit push, input bit pop);
        if (!rst) begin
            m_cnt[k]   = 0;
            m_shown[k] = '0;
        end else if (flush) begin
            m_cnt[k] = 0;
        end else begin
            if (pop) begin
                m_data[k][0] = m_data[k][1];
                m_ctrl[k][0] = m_ctrl[k][1];
                m_cnt[k]--;
            end
            if (push) begin
                m_data[k][m_cnt[k]] = in_data;
                m_ctrl[k][m_cnt[k]] = in_ctrl;
                m_cnt[k]++;
            end
            if (m_cnt[k] > 0) m_shown[k] = m_data[k][0];
        end
    endtask

    task automatic check_outputs(input int k);
        logic [CW-1:0] ec;
        ec = (m_cnt[k] > 0) ? m_ctrl[k][0] : '0;
        chk($sformatf("out_valid[%0d]", k), out_valid_w[k], m_cnt[k] > 0);
        chk($sformatf("out_data[%0d]", k), out_data_w[k], m_shown[k]);
        chk($sformatf("out_ctrl[%0d]", k), out_ctrl_w[k], ec);
        chk($sformatf("occupancy[%0d]", k), occ_w[k], m_cnt[k][1:0]);
    endtask

    // One clock: drive, check in_ready mid-cycle, clock, check outputs.
    task automatic step(input logic r, input logic fl, input logic iv,
                        input logic [DW-1:0] d, input logic [CW-1:0] c,
                        input logic ordy, output logic ir0, output logic ir1);
        bit   push [2];
        bit   pop  [2];
        logic er;
        rst = r; flush = fl; in_valid = iv; in_data = d; in_ctrl = c; out_ready = ordy;
        #1;
        for (int k = 0; k < 2; k++) begin
            er = model_ready(k);
            chk($sformatf("in_ready[%0d]", k), in_ready_w[k], er);
            push[k] = iv && er;
            pop[k]  = (m_cnt[k] > 0) && ordy;
        end
        ir0 = in_ready_w[0];
        ir1 = in_ready_w[1];
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_edge(k, push[k], pop[k]);
        #1;
        for (int k = 0; k < 2; k++) check_outputs(k);
    endtask

    typedef struct {
        logic          r, fl, iv;
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        logic          ordy;
        logic          e_ir, e_ov;
        logic [DW-1:0] e_od;
        logic [CW-1:0] e_oc;
        logic [1:0]    e_occ;
    } vec_t;

    vec_t tbl [19];

    initial begin
        logic ir0, ir1;

        for (int k = 0; k < 2; k++) begin
            m_cnt[k]   = 0;
            m_shown[k] = '0;
        end

        //          r  fl iv  data      ctrl   ordy ir ov out_data  out_ctrl occ
        tbl[0]  = '{1'b0,1'b0,1'b1,64'h99, 8'hFF,1'b1,1'b0,1'b0,64'h0,  8'h00,2'd0};
        tbl[1]  = '{1'b0,1'b0,1'b1,64'h99, 8'hFF,1'b1,1'b0,1'b0,64'h0,  8'h00,2'd0};
        tbl[2]  = '{1'b1,1'b0,1'b0,64'h0,  8'h00,1'b1,1'b1,1'b0,64'h0,  8'h00,2'd0};
        tbl[3]  = '{1'b1,1'b0,1'b1,64'hA,  8'h11,1'b0,1'b1,1'b1,64'hA,  8'h11,2'd1};
        tbl[4]  = '{1'b1,1'b0,1'b1,64'hB,  8'h22,1'b0,1'b1,1'b1,64'hA,  8'h11,2'd2};
        tbl[5]  = '{1'b1,1'b0,1'b1,64'hC,  8'h23,1'b0,1'b0,1'b1,64'hA,  8'h11,2'd2};
        tbl[6]  = '{1'b1,1'b0,1'b0,64'h0,  8'h00,1'b1,1'b0,1'b1,64'hB,  8'h22,2'd1};
        tbl[7]  = '{1'b1,1'b0,1'b0,64'h0,  8'h00,1'b1,1'b1,1'b0,64'hB,  8'h00,2'd0};
        tbl[8]  = '{1'b1,1'b0,1'b1,64'h1A, 8'h33,1'b0,1'b1,1'b1,64'h1A, 8'h33,2'd1};
        tbl[9]  = '{1'b1,1'b0,1'b1,64'h1B, 8'h44,1'b0,1'b1,1'b1,64'h1A, 8'h33,2'd2};
        tbl[10] = '{1'b1,1'b1,1'b1,64'hC,  8'h55,1'b0,1'b0,1'b0,64'h1A, 8'h00,2'd0};
        tbl[11] = '{1'b1,1'b0,1'b1,64'h2A, 8'h66,1'b0,1'b1,1'b1,64'h2A, 8'h66,2'd1};
        tbl[12] = '{1'b1,1'b1,1'b1,64'hC,  8'h77,1'b0,1'b1,1'b0,64'h2A, 8'h00,2'd0};
        tbl[13] = '{1'b1,1'b0,1'b0,64'h0,  8'h00,1'b1,1'b1,1'b0,64'h2A, 8'h00,2'd0};
        tbl[14] = '{1'b1,1'b0,1'b1,64'hD,  8'h5A,1'b1,1'b1,1'b1,64'hD,  8'h5A,2'd1};
        tbl[15] = '{1'b1,1'b0,1'b0,64'h0,  8'h00,1'b1,1'b1,1'b0,64'hD,  8'h00,2'd0};
        tbl[16] = '{1'b1,1'b0,1'b1,64'hE,  8'h12,1'b0,1'b1,1'b1,64'hE,  8'h12,2'd1};
        tbl[17] = '{1'b0,1'b1,1'b1,64'hF,  8'hFF,1'b0,1'b0,1'b0,64'h0,  8'h00,2'd0};
        tbl[18] = '{1'b1,1'b0,1'b0,64'h0,  8'h00,1'b1,1'b1,1'b0,64'h0,  8'h00,2'd0};

        for (int i = 0; i < 19; i++) begin
            step(tbl[i].r, tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].c, tbl[i].ordy, ir0, ir1);
            chk($sformatf("vec%0d in_ready", i), ir0, tbl[i].e_ir);
            chk($sformatf("vec%0d out_valid", i), out_valid_w[0], tbl[i].e_ov);
            chk($sformatf("vec%0d out_data", i), out_data_w[0], tbl[i].e_od);
            chk($sformatf("vec%0d out_ctrl", i), out_ctrl_w[0], tbl[i].e_oc);
            chk($sformatf("vec%0d occupancy", i), occ_w[0], tbl[i].e_occ);
        end

        // Streaming: each value visible one edge after its push.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, 1'b1, DW'(i), CW'(8'h80 | i), 1'b1, ir0, ir1);
            chk($sformatf("stream%0d data", i), out_data_w[0], DW'(i));
            chk($sformatf("stream%0d valid", i), out_valid_w[0], 1'b1);
            chk($sformatf("stream%0d occ", i), occ_w[0], 2'd1);
        end
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, ir0, ir1);

        // Single-entry stage: in_ready follows out_ready within the cycle.
        step(1'b1, 1'b0, 1'b1, 64'h55, 8'h0F, 1'b0, ir0, ir1);
        step(1'b1, 1'b0, 1'b1, 64'h66, 8'h1E, 1'b0, ir0, ir1);
        chk("noskid stall in_ready", ir1, 1'b0);
        chk("noskid stall data", out_data_w[1], 64'h55);
        step(1'b1, 1'b0, 1'b1, 64'h77, 8'h2D, 1'b1, ir0, ir1);
        chk("noskid pass in_ready", ir1, 1'b1);
        chk("noskid pass occ", occ_w[1], 2'd1);
        chk("noskid pass data", out_data_w[1], 64'h77);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(63) != 0,
                 $urandom_range(15) == 0,
                 $urandom_range(3) != 0,
                 {$urandom, $urandom},
                 CW'($urandom),
                 $urandom_range(4) < 3,
                 ir0, ir1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register, the successor to the fixed-field stage latches between EX/MEM/WB. Carries an opaque payload plus a control field that is forced to zero on bubbles. Adds valid/ready handshaking, stall (back-pressure), flush, and an optional skid entry so upstream ready is fully registered. Instantiated once per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) with stage-specific widths.

Parameters:
DATA_W, 64, payload width (ALU result, store data, dest reg, flags), passed through unmodified
CTRL_W, 8, control-field width (WB/MEM enables, jal, etc.), zeroed whenever the stage holds a bubble
SKID, 1, 1 = two-entry stage (main + skid, registered in_ready); 0 = single entry (in_ready combinational)

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset; one clock; reset is synchronous and active-low
flush  in  1  kill stage contents (branch/jump redirect), synchronous
in_valid  in  1  upstream holds a valid instruction
in_ready  out  1  stage can accept this cycle
in_data  in  DATA_W  upstream payload
in_ctrl  in  CTRL_W  upstream control field
out_valid  out  1  stage output valid
out_ready  in  1  downstream accepts this cycle
out_data  out  DATA_W  payload to next stage
out_ctrl  out  CTRL_W  control to next stage; all-zero when out_valid=0
occupancy  out  2  entries held (0..2; max 1 when SKID=0)

Behaviour:
- Transfers: push = in_valid & in_ready; pop = out_valid & out_ready; both evaluated on the same rising edge.
- Reset (rst=0 at an edge): out_valid=0, out_data=0, out_ctrl=0, occupancy=0, skid entry cleared. in_ready forced 0 while rst=0; inputs ignored.
- SKID=1, states EMPTY/ONE/TWO (occupancy 0/1/2). in_ready = (state != TWO), taken from registered state only (no out_ready path).
  - EMPTY: push -> ONE, main <= input.
  - ONE: push & pop -> ONE, main <= input. Push only -> TWO, skid <= input. Pop only -> EMPTY.
  - TWO: push impossible. Pop -> ONE, main <= skid. No pop -> hold.
- SKID=0: in_ready = ~out_valid | out_ready. Push -> main <= input, out_valid=1. Pop without push -> out_valid=0.
- Latency: 1 cycle input-to-output when not stalled; order is strictly FIFO.
- Bubble: whenever out_valid becomes 0, out_ctrl <= 0 in the same edge. out_data holds its last value.
- Flush (rst=1, flush=1): all entries invalidated, out_valid=0, out_ctrl=0, occupancy=0. A push in the same cycle is dropped (flush wins). A pop in the same cycle still counts for the downstream stage.
- Reset during operation behaves exactly like reset from idle. Reset takes priority over flush.
- Stall: out_ready=0 with out_valid=1 holds out_data/out_ctrl stable (no glitching); entries are never overwritten while valid.

Decomposition:
- Shared package pipe_pkg holds stage payload width constants (EXMEM_DATA_W, EXMEM_CTRL_W, ...) and the state encoding localparams (ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2).
- No sub-module. The skid entry is a generate-if on SKID within this module.

Test Plan:
- Reset: rst=0 for 2 cycles with in_valid=1, in_ctrl=8'hFF -> out_valid=0, out_ctrl=0, occupancy=0, in_ready=0. After release, in_ready=1.
- Streaming, SKID=1: 8 back-to-back pushes, data 1..8, out_ready=1 -> out_data 1..8 on consecutive cycles, each 1 cycle after its push; occupancy stays 1.
- Stall: push A,B with out_ready=0 -> occupancy=2, in_ready=0, out_data=A held. Raise out_ready -> A then B appear, no loss or duplication.
- Flush with push: occupancy=2, flush=1 and in_valid=1 (data C) on the same edge -> out_valid=0, out_ctrl=0, occupancy=0; C never appears at the output.
- Bubble: push D (ctrl 8'h5A), pop it with no new push -> out_valid=0, out_ctrl=0, out_data still D.
- SKID=0: out_ready=0 with the stage full -> in_ready=0 in the same cycle. out_ready=1 -> simultaneous push and pop, occupancy remains 1.
